bmp_ram_arbiter: RTL and testbench
==================================

// Module: bmp_ram_arbiter
// PURPOSE
//  - Shares the single-port BMP RAM between two requesters with round-robin arbitration.
//  - Requester 0 is the BMP loader (ROM->RAM copy); requester 1 is the pixel-processing engine.
//  - Sits between both requesters and the RAM; registers all RAM controls and returns read data.
// PARAMETERS
//  ADDR_WIDTH  20  RAM byte address width (covers 512x512x3 + 54-byte header)
//  BYTE_WIDTH  8   RAM data width
//  HDR_SIZE    54  BMP header length in bytes (used only with HDR_PROTECT_EN)
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           synchronous, active-high reset
//  req0       in   1           requester 0 command request
//  wen0       in   1           requester 0: 1 = write, 0 = read
//  addr0      in   ADDR_WIDTH  requester 0 byte address
//  wdata0     in   BYTE_WIDTH  requester 0 write data
//  gnt0       out  1           requester 0 command accepted this cycle
//  rvalid0    out  1           requester 0 read data valid
//  req1/wen1/addr1/wdata1/gnt1/rvalid1  same as above, for requester 1
//  rdata      out  BYTE_WIDTH  read data (shared; qualified by rvalid0/rvalid1)
//  RAM_ren    out  1           RAM read enable
//  RAM_wen    out  1           RAM write enable
//  RAM_addr   out  ADDR_WIDTH  RAM address
//  RAM_in     out  BYTE_WIDTH  RAM write data
//  RAM_out    in   BYTE_WIDTH  RAM read data, valid 1 cycle after RAM_ren
//  err_wp     out  1           sticky header-write-violation flag
// BEHAVIOUR
//  - Reset (rst=1 at posedge): RAM_ren=0, RAM_wen=0, RAM_addr=0, RAM_in=0, rvalid0/1=0,
//    err_wp=0, last-grant pointer=1 (requester 0 wins first tie); gnt0/gnt1 forced 0 while rst=1.
//  - Grant is combinational: a single requester is granted in the same cycle; on a tie,
//    grant goes to the requester NOT recorded in last-grant. Accept = req & gnt.
//  - last-grant updates only on accept; it does not change in idle cycles.
//  - Requester holds req/wen/addr/wdata stable until gnt; it may change them in the cycle after gnt.
//  - Accept in cycle N -> RAM_ren/RAM_wen/RAM_addr/RAM_in registered and driven in N+1.
//  - Read accepted in N: rvalid_x=1 for exactly one cycle in N+2, rdata=RAM_out.
//  - Write accepted in N: no response; the RAM write occurs at the end of N+1.
//  - No accept in N: RAM_ren=RAM_wen=0 in N+1; RAM_addr/RAM_in hold their previous values.
//  - Throughput: one command per cycle; back-to-back accepts from the same or alternating requesters.
//  - Continuous contention: grants strictly alternate 0,1,0,1,...; there is no starvation.
//  - A 2-deep tag pipeline (valid, id) tracks reads; rvalid0 and rvalid1 are never both 1.
//  - Reset mid-operation: in-flight reads are dropped (no rvalid); in-flight writes may be lost.
//  - Address is passed through unchanged; no range check beyond ADDR_WIDTH.
// CONFIGURATION
//  - HDR_PROTECT_EN defined: a write from requester 1 with addr1 < HDR_SIZE is still granted
//    (gnt1=1), but RAM_wen stays 0 in N+1 and err_wp sets at the end of N and holds until rst.
//    Requester 0 writes are never blocked.
//  - HDR_PROTECT_EN undefined: all writes pass; err_wp tied to 0.
// TESTING
//  - Reset: assert rst for 2 cycles with req0=req1=1 -> gnt0=gnt1=0, all RAM controls and rvalids 0.
//  - Single write: req0,wen0=1,addr0=0x00010,wdata0=0xA5 -> gnt0 in N; RAM_wen=1,
//    RAM_addr=0x00010, RAM_in=0xA5 in N+1.
//  - Read-back: req1,wen1=0,addr1=0x00010 after the write -> rvalid1=1 and rdata=0xA5 two cycles
//    after gnt1; rvalid0=0.
//  - Contention: req0=req1=1 held for 6 cycles after reset -> grant order 0,1,0,1,0,1; RAM_ren=1
//    every cycle; each rvalid targets the correct requester.
//  - Reset mid-read: accept read in N, rst=1 in N+1 -> no rvalid in N+2; all outputs at reset values.
//  - HDR_PROTECT_EN: req1 write addr1=53 -> gnt1=1, RAM_wen=0, err_wp=1; addr1=54 -> RAM_wen=1;
//    a requester 0 write to addr0=0 -> RAM_wen=1.

Source files
------------

// File: rtl/bmp_ram_arbiter.sv
// Purpose    : shares the single-port BMP RAM between the loader (req 0) and the pixel engine (req 1).
// Latency    : command accepted in N drives the RAM in N+1; read data returns with rvalid in N+2.
// Backpressure: combinational round-robin grant; a requester holds its command until gnt.
//
// Ports
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   req0/wen0/addr0/wdata0/gnt0  requester 0 (BMP loader) command + grant
//   req1/wen1/addr1/wdata1/gnt1  requester 1 (pixel engine) command + grant
//   rvalid0, rvalid1, rdata      read response; rdata is shared and qualified by rvalid0/rvalid1
//   RAM_ren/RAM_wen/RAM_addr/RAM_in/RAM_out  registered RAM controls, raw RAM read data
//   err_wp                       sticky header-write-violation flag
//
// Build option: define HDR_PROTECT_EN to suppress requester-1 writes below HDR_SIZE and
// flag them on err_wp. Without it every write reaches the RAM and err_wp stays 0.

module bmp_ram_arbiter #(
  parameter int ADDR_WIDTH = 20,
  parameter int BYTE_WIDTH = 8,
  parameter int HDR_SIZE   = 54
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0,
  input  logic                  wen0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [BYTE_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,

  input  logic                  req1,
  input  logic                  wen1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [BYTE_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,

  output logic [BYTE_WIDTH-1:0] rdata,

  output logic                  RAM_ren,
  output logic                  RAM_wen,
  output logic [ADDR_WIDTH-1:0] RAM_addr,
  output logic [BYTE_WIDTH-1:0] RAM_in,
  input  logic [BYTE_WIDTH-1:0] RAM_out,

  output logic                  err_wp
);

`ifdef HDR_PROTECT_EN
  localparam logic HDR_PROTECT = 1'b1;
`else
  localparam logic HDR_PROTECT = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] HDR_LIMIT = ADDR_WIDTH'(HDR_SIZE);

  // Identity of the requester that won the most recent accept. Resets to 1
  // so that requester 0 wins the very first tie.
  logic last_gnt;

  // Selected command (valid only when cmd_acc is high).
  logic                  cmd_acc;
  logic                  cmd_id;
  logic                  cmd_wen;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [BYTE_WIDTH-1:0] cmd_wdata;
  logic                  cmd_block;

  // Read tag pipeline: stage 1 lines up with RAM_ren, stage 2 with RAM_out.
  logic tag1_vld;
  logic tag1_id;
  logic tag2_vld;
  logic tag2_id;

  // ---------------------------------------------------------------------------
  // Round-robin grant. A lone requester always wins; on a tie the requester
  // that did not win last time is served, which gives strict alternation
  // under continuous contention.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt0 = req0 && (!req1 || last_gnt);
      gnt1 = req1 && (!req0 || !last_gnt);
    end
  end

  // Command mux: at most one grant is ever high, so gnt1 alone selects.
  always_comb begin
    cmd_acc   = gnt0 || gnt1;
    cmd_id    = gnt1;
    cmd_wen   = gnt1 ? wen1   : wen0;
    cmd_addr  = gnt1 ? addr1  : addr0;
    cmd_wdata = gnt1 ? wdata1 : wdata0;
  end

  // Pixel-engine write into the BMP header region. Still granted (so the
  // engine is not stalled forever) but dropped on the way to the RAM.
  always_comb begin
    cmd_block = HDR_PROTECT && gnt1 && wen1 && (addr1 < HDR_LIMIT);
  end

  // ---------------------------------------------------------------------------
  // Arbitration state and registered RAM controls.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
      RAM_ren  <= 1'b0;
      RAM_wen  <= 1'b0;
      RAM_addr <= '0;
      RAM_in   <= '0;
    end else begin
      RAM_ren <= cmd_acc && !cmd_wen;
      RAM_wen <= cmd_acc && cmd_wen && !cmd_block;
      if (cmd_acc) begin
        last_gnt <= cmd_id;
        RAM_addr <= cmd_addr;
        RAM_in   <= cmd_wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read tag pipeline. Clearing on reset drops any read still in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tag1_vld <= 1'b0;
      tag1_id  <= 1'b0;
      tag2_vld <= 1'b0;
      tag2_id  <= 1'b0;
    end else begin
      tag1_vld <= cmd_acc && !cmd_wen;
      tag1_id  <= cmd_id;
      tag2_vld <= tag1_vld;
      tag2_id  <= tag1_id;
    end
  end

  always_comb begin
    rvalid0 = tag2_vld && !tag2_id;
    rvalid1 = tag2_vld &&  tag2_id;
    rdata   = RAM_out;
  end

  // ---------------------------------------------------------------------------
  // Sticky header-write violation. cmd_block is constant 0 when protection is
  // compiled out, leaving err_wp permanently low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      err_wp <= 1'b0;
    end else if (cmd_block) begin
      err_wp <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Structural invariants.
  // ---------------------------------------------------------------------------
  a_one_grant : assert property (@(posedge clk) !(gnt0 && gnt1));
  a_one_rvalid: assert property (@(posedge clk) !(rvalid0 && rvalid1));
  a_one_op    : assert property (@(posedge clk) !(RAM_ren && RAM_wen));

endmodule

// File: tb/tb_bmp_ram_arbiter.sv
module tb_bmp_ram_arbiter;

  localparam int AW = 20;
  localparam int BW = 8;
  localparam int HS = 54;

`ifdef HDR_PROTECT_EN
  localparam logic PROT = 1'b1;
`else
  localparam logic PROT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, wen0, req1, wen1;
  logic [AW-1:0] addr0, addr1;
  logic [BW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [BW-1:0] rdata;
  logic          RAM_ren, RAM_wen;
  logic [AW-1:0] RAM_addr;
  logic [BW-1:0] RAM_in;
  logic [BW-1:0] RAM_out;
  logic          err_wp;

  bmp_ram_arbiter #(.ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .HDR_SIZE(HS)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .wen0(wen0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .wen1(wen1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata),
    .RAM_ren(RAM_ren), .RAM_wen(RAM_wen), .RAM_addr(RAM_addr), .RAM_in(RAM_in),
    .RAM_out(RAM_out), .err_wp(err_wp)
  );

  always #5 clk = ~clk;

  // Single-port RAM model with one-cycle read latency.
  logic [BW-1:0] ram [0:1023];
  logic          ram_clr;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= '0;
    end else begin
      if (RAM_wen) ram[RAM_addr[9:0]] <= RAM_in;
      if (RAM_ren) RAM_out <= ram[RAM_addr[9:0]];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; wen0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; wen1 = 1'b0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1; ram_clr = 1'b1;
    step(); step();
    rst = 1'b0; ram_clr = 1'b0;
  endtask

  // Directed vector table: inputs for one cycle, the expected grant in that
  // cycle and the expected RAM controls in the following cycle.
  typedef struct {
    logic          req0, wen0; logic [AW-1:0] addr0; logic [BW-1:0] wdata0;
    logic          req1, wen1; logic [AW-1:0] addr1; logic [BW-1:0] wdata1;
    logic          g0, g1;
    logic          nren, nwen; logic [AW-1:0] naddr; logic [BW-1:0] nin;
  } vec_t;
  vec_t tbl [9];

  // Random-phase reference model state.
  typedef struct { int due; logic id; logic [BW-1:0] d; } resp_t;
  resp_t         rq [$];
  logic [BW-1:0] ref_mem [0:255];
  logic          pend [2];
  logic          pwen [2];
  logic [AW-1:0] paddr [2];
  logic [BW-1:0] pdat [2];

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [6];
    rst = 1'b1; ram_clr = 1'b1;
    idle_inputs();

    // ---------------- reset with both requesting ----------------
    req0 = 1'b1; req1 = 1'b1;
    #1;
    check("rst_gnt0_c0", gnt0, 0);
    check("rst_gnt1_c0", gnt1, 0);
    step();
    check("rst_gnt0_c1", gnt0, 0);
    check("rst_gnt1_c1", gnt1, 0);
    step();
    check("rst_ram_ren", RAM_ren, 0);
    check("rst_ram_wen", RAM_wen, 0);
    check("rst_ram_addr", RAM_addr, 0);
    check("rst_ram_in", RAM_in, 0);
    check("rst_rvalid0", rvalid0, 0);
    check("rst_rvalid1", rvalid1, 0);
    check("rst_err_wp", err_wp, 0);
    idle_inputs();
    rst = 1'b0; ram_clr = 1'b0;

    // ---------------- single write then read-back ----------------
    do_reset();
    req0 = 1'b1; wen0 = 1'b1; addr0 = 20'h00010; wdata0 = 8'hA5;
    #1;
    check("wr_gnt0", gnt0, 1);
    check("wr_gnt1", gnt1, 0);
    step();
    idle_inputs();
    check("wr_ram_wen", RAM_wen, 1);
    check("wr_ram_ren", RAM_ren, 0);
    check("wr_ram_addr", RAM_addr, 20'h00010);
    check("wr_ram_in", RAM_in, 8'hA5);
    req1 = 1'b1; wen1 = 1'b0; addr1 = 20'h00010;
    #1;
    check("rd_gnt1", gnt1, 1);
    step();
    idle_inputs();
    check("rd_ram_ren", RAM_ren, 1);
    check("rd_ram_addr", RAM_addr, 20'h00010);
    check("rd_rvalid1_early", rvalid1, 0);
    step();
    check("rd_rvalid1", rvalid1, 1);
    check("rd_rvalid0", rvalid0, 0);
    check("rd_rdata", rdata, 8'hA5);
    step();
    check("rd_rvalid1_once", rvalid1, 0);

    // ---------------- table-driven grant / RAM control vectors ----------------
    tbl[0] = '{1'b1,1'b0,20'h100,8'h00, 1'b1,1'b0,20'h200,8'h00, 1'b1,1'b0, 1'b1,1'b0,20'h100,8'h00};
    tbl[1] = '{1'b1,1'b0,20'h101,8'h00, 1'b1,1'b0,20'h200,8'h00, 1'b0,1'b1, 1'b1,1'b0,20'h200,8'h00};
    tbl[2] = '{1'b1,1'b1,20'h102,8'h3C, 1'b0,1'b0,20'h000,8'h00, 1'b1,1'b0, 1'b0,1'b1,20'h102,8'h3C};
    tbl[3] = '{1'b1,1'b0,20'h103,8'h00, 1'b0,1'b0,20'h000,8'h00, 1'b1,1'b0, 1'b1,1'b0,20'h103,8'h00};
    tbl[4] = '{1'b0,1'b0,20'h000,8'h00, 1'b0,1'b0,20'h000,8'h00, 1'b0,1'b0, 1'b0,1'b0,20'h103,8'h00};
    tbl[5] = '{1'b1,1'b0,20'h104,8'h00, 1'b1,1'b1,20'h205,8'h77, 1'b0,1'b1, 1'b0,1'b1,20'h205,8'h77};
    tbl[6] = '{1'b1,1'b0,20'h104,8'h00, 1'b1,1'b0,20'h206,8'h00, 1'b1,1'b0, 1'b1,1'b0,20'h104,8'h00};
    tbl[7] = '{1'b1,1'b0,20'h107,8'h00, 1'b1,1'b0,20'h206,8'h00, 1'b0,1'b1, 1'b1,1'b0,20'h206,8'h00};
    tbl[8] = '{1'b0,1'b0,20'h000,8'h00, 1'b0,1'b0,20'h000,8'h00, 1'b0,1'b0, 1'b0,1'b0,20'h206,8'h00};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      req0 = tbl[i].req0; wen0 = tbl[i].wen0; addr0 = tbl[i].addr0; wdata0 = tbl[i].wdata0;
      req1 = tbl[i].req1; wen1 = tbl[i].wen1; addr1 = tbl[i].addr1; wdata1 = tbl[i].wdata1;
      #1;
      check($sformatf("vec%0d_gnt0", i), gnt0, tbl[i].g0);
      check($sformatf("vec%0d_gnt1", i), gnt1, tbl[i].g1);
      step();
      check($sformatf("vec%0d_ram_ren", i), RAM_ren, tbl[i].nren);
      check($sformatf("vec%0d_ram_wen", i), RAM_wen, tbl[i].nwen);
      check($sformatf("vec%0d_ram_addr", i), RAM_addr, tbl[i].naddr);
      if (tbl[i].nwen) check($sformatf("vec%0d_ram_in", i), RAM_in, tbl[i].nin);
    end
    idle_inputs();

    // ---------------- continuous contention after reset ----------------
    do_reset();
    req0 = 1'b1; wen0 = 1'b0; addr0 = 20'h00020;
    req1 = 1'b1; wen1 = 1'b0; addr1 = 20'h00030;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) idle_inputs();
      #1;
      if (c < 6) begin
        order[c] = gnt1 ? 1 : 0;
        check($sformatf("cont_c%0d_gnt0", c), gnt0, (c % 2) == 0);
        check($sformatf("cont_c%0d_gnt1", c), gnt1, (c % 2) == 1);
      end
      if (c >= 1 && c <= 6) check($sformatf("cont_c%0d_ram_ren", c), RAM_ren, 1);
      if (c >= 2) begin
        check($sformatf("cont_c%0d_rvalid0", c), rvalid0, ((c - 2) % 2) == 0);
        check($sformatf("cont_c%0d_rvalid1", c), rvalid1, ((c - 2) % 2) == 1);
      end
      step();
    end
    check("cont_order_last", order[5], 1);

    // ---------------- reset in the middle of a read ----------------
    do_reset();
    req0 = 1'b1; wen0 = 1'b0; addr0 = 20'h00055;
    #1;
    check("mid_gnt0", gnt0, 1);
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    check("mid_rvalid0", rvalid0, 0);
    check("mid_rvalid1", rvalid1, 0);
    check("mid_ram_ren", RAM_ren, 0);
    check("mid_ram_wen", RAM_wen, 0);
    check("mid_ram_addr", RAM_addr, 0);
    check("mid_ram_in", RAM_in, 0);
    check("mid_err_wp", err_wp, 0);
    rst = 1'b0;
    step();
    check("mid_rvalid0_after", rvalid0, 0);

    // ---------------- randomized traffic against the reference model ----------------
    begin
      int            nxt;       // requester that wins the next tie
      int            w;
      logic          e_ren, e_wen, e_err, blocked;
      logic [AW-1:0] e_addr;
      logic [BW-1:0] e_in;
      resp_t         r;
      do_reset();
      for (int a = 0; a < 256; a++) ref_mem[a] = '0;
      for (int k = 0; k < 2; k++) begin
        pend[k] = 1'b0; pwen[k] = 1'b0; paddr[k] = '0; pdat[k] = '0;
      end
      rq.delete();
      nxt = 0; e_ren = 1'b0; e_wen = 1'b0; e_err = 1'b0; e_addr = '0; e_in = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        for (int k = 0; k < 2; k++) begin
          if (!pend[k] && $urandom_range(0, 3) != 0) begin
            pend[k]  = 1'b1;
            pwen[k]  = 1'($urandom_range(0, 1));
            paddr[k] = AW'($urandom_range(0, 255));
            pdat[k]  = BW'($urandom);
          end
        end
        req0 = pend[0]; wen0 = pwen[0]; addr0 = paddr[0]; wdata0 = pdat[0];
        req1 = pend[1]; wen1 = pwen[1]; addr1 = paddr[1]; wdata1 = pdat[1];
        #1;
        if (pend[0] && pend[1]) w = nxt;
        else if (pend[0])       w = 0;
        else if (pend[1])       w = 1;
        else                    w = -1;
        check("rnd_gnt0", gnt0, w == 0);
        check("rnd_gnt1", gnt1, w == 1);
        check("rnd_ram_ren", RAM_ren, e_ren);
        check("rnd_ram_wen", RAM_wen, e_wen);
        check("rnd_ram_addr", RAM_addr, e_addr);
        if (e_wen) check("rnd_ram_in", RAM_in, e_in);
        check("rnd_err_wp", err_wp, e_err);
        if (rq.size() > 0 && rq[0].due == cyc) begin
          r = rq.pop_front();
          check("rnd_rvalid0", rvalid0, r.id == 1'b0);
          check("rnd_rvalid1", rvalid1, r.id == 1'b1);
          check("rnd_rdata", rdata, r.d);
        end else begin
          check("rnd_rvalid0_idle", rvalid0, 0);
          check("rnd_rvalid1_idle", rvalid1, 0);
        end
        e_ren = 1'b0; e_wen = 1'b0;
        if (w >= 0) begin
          nxt     = 1 - w;
          blocked = PROT && (w == 1) && pwen[w] && (paddr[w] < AW'(HS));
          e_addr  = paddr[w];
          e_in    = pdat[w];
          e_ren   = !pwen[w];
          e_wen   = pwen[w] && !blocked;
          if (blocked) e_err = 1'b1;
          if (!pwen[w]) rq.push_back('{cyc + 2, (w == 1), ref_mem[paddr[w][7:0]]});
          else if (!blocked) ref_mem[paddr[w][7:0]] = pdat[w];
          pend[w] = 1'b0;
        end
        step();
      end
      idle_inputs();
    end

`ifdef HDR_PROTECT_EN
    // ---------------- header write protection ----------------
    do_reset();
    req1 = 1'b1; wen1 = 1'b1; addr1 = 20'd53; wdata1 = 8'h11;
    #1;
    check("hp53_gnt1", gnt1, 1);
    step();
    idle_inputs();
    check("hp53_ram_wen", RAM_wen, 0);
    check("hp53_err_wp", err_wp, 1);
    req1 = 1'b1; wen1 = 1'b1; addr1 = 20'd54; wdata1 = 8'h22;
    #1;
    check("hp54_gnt1", gnt1, 1);
    step();
    idle_inputs();
    check("hp54_ram_wen", RAM_wen, 1);
    check("hp54_ram_addr", RAM_addr, 20'd54);
    req0 = 1'b1; wen0 = 1'b1; addr0 = 20'd0; wdata0 = 8'h33;
    #1;
    check("hp0_gnt0", gnt0, 1);
    step();
    idle_inputs();
    check("hp0_ram_wen", RAM_wen, 1);
    check("hp0_ram_addr", RAM_addr, 0);
    check("hp_err_sticky", err_wp, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
